// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter
//   Shares one single-port synchronous memory between the instruction-fetch
//   port and the data port of a pipelined datapath. One access is in flight
//   at a time; reads wait MEM_LAT cycles for the memory, writes complete on
//   the next cycle. Per-port stalls freeze the datapath until it is served.
//
// Handshake (both ports): a request is a level held until its oXValid pulse.
//   oXValid is a one-cycle pulse that ends the request; during that cycle the
//   same port is not eligible, so the held level is not granted a second time.
//   Any request level seen after the pulse cycle is a new request. Address and
//   write data are taken only in the grant cycle.
//
// oGrant shows the active owner: the winner in an issue cycle, the read owner
//   while waiting for memory data, and 00 otherwise.

module unified_mem_arbiter #(
  parameter int MEM_LAT    = 2,
  parameter int STARVE_MAX = 3
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iIReq,
  input  logic [31:0] iIAddr,
  output logic [31:0] oIRdata,
  output logic        oIValid,
  output logic        oIStall,
  input  logic        iDRead,
  input  logic        iDWrite,
  input  logic [31:0] iDAddr,
  input  logic [31:0] iDWdata,
  input  logic [3:0]  iDBE,
  output logic [31:0] oDRdata,
  output logic        oDValid,
  output logic        oDStall,
  output logic [31:0] oMAddr,
  output logic [31:0] oMWdata,
  output logic [3:0]  oMBE,
  output logic        oMRead,
  output logic        oMWrite,
  input  logic [31:0] iMRdata,
  output logic [1:0]  oGrant
);

  localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
  localparam logic [SW-1:0] STARVE_TOP = SW'(STARVE_MAX);
  localparam logic [2:0]    LAT_LAST   = 3'(MEM_LAT - 1);
  localparam bit            LAT_ONE    = (MEM_LAT == 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t          state;
  state_t          stateNext;
  logic [2:0]      latCnt;
  logic [1:0]      owner;       // {data, IF} owner of the read in flight
  logic [SW-1:0]   starveCnt;

  logic            ifElig;
  logic            dElig;
  logic            grantI;
  logic            grantD;
  logic            dWrIssue;
  logic            rdIssue;
  logic            latDone;
  logic [1:0]      readOwner;

  // A port that is completing this cycle must not be re-granted its old request.
  assign ifElig = iIReq & ~oIValid;
  assign dElig  = (iDRead | iDWrite) & ~oDValid;

  assign oIStall = iIReq & ~oIValid;
  assign oDStall = (iDRead | iDWrite) & ~oDValid;

  // Arbitration: data first, unless IF has been passed over STARVE_MAX times.
  always_comb begin
    grantI = 1'b0;
    grantD = 1'b0;
    if (state == ST_IDLE && !iRST) begin
      if (ifElig && starveCnt == STARVE_TOP) begin
        grantI = 1'b1;
      end else if (dElig) begin
        grantD = 1'b1;
      end else if (ifElig) begin
        grantI = 1'b1;
      end
    end
  end

  // Read+write together on the data port is a write.
  assign dWrIssue = grantD & iDWrite;
  assign rdIssue  = grantI | (grantD & ~iDWrite);

  // Memory command straight from the winner in the issue cycle; idle otherwise.
  always_comb begin
    oMAddr  = '0;
    oMWdata = '0;
    oMBE    = '0;
    oMRead  = 1'b0;
    oMWrite = 1'b0;
    if (grantI) begin
      oMAddr = iIAddr;
      oMRead = 1'b1;
    end else if (grantD) begin
      oMAddr = iDAddr;
      if (iDWrite) begin
        oMWrite = 1'b1;
        oMWdata = iDWdata;
        oMBE    = iDBE;
      end else begin
        oMRead = 1'b1;
      end
    end
  end

  // Next state and read-completion detection.
  always_comb begin
    stateNext = state;
    latDone   = 1'b0;
    readOwner = owner;
    case (state)
      ST_IDLE: begin
        readOwner = {grantD, grantI};
        if (rdIssue) begin
          if (LAT_ONE) begin
            latDone = 1'b1;
          end else begin
            stateNext = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (latCnt == LAT_LAST) begin
          latDone   = 1'b1;
          stateNext = ST_IDLE;
        end
      end
      default: stateNext = ST_IDLE;
    endcase
  end

  // Debug view of who owns the memory port this cycle.
  always_comb begin
    oGrant = 2'b00;
    if (!iRST) begin
      if (grantI) begin
        oGrant = 2'b01;
      end else if (grantD) begin
        oGrant = 2'b10;
      end else if (state == ST_WAIT) begin
        oGrant = owner;
      end
    end
  end

  // FSM state register.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      state <= ST_IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Latency counter and read owner for the access in flight.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      latCnt <= '0;
      owner  <= 2'b00;
    end else begin
      if (rdIssue) begin
        latCnt <= 3'd1;
        owner  <= {grantD, grantI};
      end else if (state == ST_WAIT) begin
        latCnt <= latCnt + 3'd1;
      end
    end
  end

  // Starvation counter: counts data grants that IF had to watch.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      starveCnt <= '0;
    end else if (grantI || !iIReq) begin
      starveCnt <= '0;
    end else if (grantD && starveCnt < STARVE_TOP) begin
      starveCnt <= starveCnt + 1'b1;
    end
  end

  // Completion pulses and read-data capture; rdata holds between completions.
  always_ff @(posedge iCLK) begin
    if (iRST) begin
      oIValid <= 1'b0;
      oDValid <= 1'b0;
      oIRdata <= '0;
      oDRdata <= '0;
    end else begin
      oIValid <= latDone & readOwner[0];
      oDValid <= (latDone & readOwner[1]) | dWrIssue;
      if (latDone && readOwner[0]) begin
        oIRdata <= iMRdata;
      end
      if (latDone && readOwner[1]) begin
        oDRdata <= iMRdata;
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter
//   Directed scenarios with literal expectations, then randomized traffic on
//   both ports. A transaction-level reference (busy time, one pending read
//   with a due cycle, a memory image) is compared with the DUT every cycle.

module tb_unified_mem_arbiter;

  localparam int MEM_LAT    = 2;
  localparam int STARVE_MAX = 3;

  logic        iCLK;
  logic        iRST;
  logic        iIReq;
  logic [31:0] iIAddr;
  logic [31:0] oIRdata;
  logic        oIValid;
  logic        oIStall;
  logic        iDRead;
  logic        iDWrite;
  logic [31:0] iDAddr;
  logic [31:0] iDWdata;
  logic [3:0]  iDBE;
  logic [31:0] oDRdata;
  logic        oDValid;
  logic        oDStall;
  logic [31:0] oMAddr;
  logic [31:0] oMWdata;
  logic [3:0]  oMBE;
  logic        oMRead;
  logic        oMWrite;
  logic [31:0] iMRdata;
  logic [1:0]  oGrant;

  unified_mem_arbiter #(
    .MEM_LAT   (MEM_LAT),
    .STARVE_MAX(STARVE_MAX)
  ) dut (
    .iCLK   (iCLK),
    .iRST   (iRST),
    .iIReq  (iIReq),
    .iIAddr (iIAddr),
    .oIRdata(oIRdata),
    .oIValid(oIValid),
    .oIStall(oIStall),
    .iDRead (iDRead),
    .iDWrite(iDWrite),
    .iDAddr (iDAddr),
    .iDWdata(iDWdata),
    .iDBE   (iDBE),
    .oDRdata(oDRdata),
    .oDValid(oDValid),
    .oDStall(oDStall),
    .oMAddr (oMAddr),
    .oMWdata(oMWdata),
    .oMBE   (oMBE),
    .oMRead (oMRead),
    .oMWrite(oMWrite),
    .iMRdata(iMRdata),
    .oGrant (oGrant)
  );

  // ---------------- clock / reset ----------------
  initial iCLK = 1'b0;
  always #5 iCLK = ~iCLK;

  int nVec = 0;
  int nMis = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nMis++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h3C5A_96E1;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) begin
      if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1001_0000 + {26'd0, 4'($urandom_range(0, 15)), 2'b00};
  endfunction

  // ---------------- memory device (reacts to the DUT's strobes) ----------------
  logic [31:0] devMem [logic [31:0]];
  logic [31:0] refMem [logic [31:0]];

  function automatic logic [31:0] dev_read(input logic [31:0] a);
    return devMem.exists(a) ? devMem[a] : dflt(a);
  endfunction

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return refMem.exists(a) ? refMem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [31:0] v);
    devMem[a] = v;
    refMem[a] = v;
  endtask

  // Read data appears MEM_LAT-1 cycles after the command; garbage otherwise.
  initial iMRdata = '0;
  always @(posedge iCLK) begin
    if (oMWrite) devMem[oMAddr] = merge(dev_read(oMAddr), oMWdata, oMBE);
    iMRdata <= oMRead ? dev_read(oMAddr) : $urandom();
  end

  // ---------------- reference model + per-cycle compare ----------------
  logic        mIValid = 1'b0;
  logic        mDValid = 1'b0;
  logic [31:0] mIRdata = '0;
  logic [31:0] mDRdata = '0;
  int          busyLeft = 0;
  int          starve = 0;
  int          cyc = 0;
  logic        pendActive = 1'b0;
  int          pendDue = 0;
  logic        pendIsI = 1'b0;
  logic [31:0] pendData = '0;
  logic [1:0]  waitOwner = 2'b00;

  always @(negedge iCLK) begin : ref_model
    logic ifPend, dPend, eI, eD, eRead, eWrite, nI, nD;
    logic [1:0] eGrant;
    ifPend = iIReq && !mIValid;
    dPend  = (iDRead || iDWrite) && !mDValid;
    eI = 1'b0;
    eD = 1'b0;
    if (!iRST && busyLeft == 0) begin
      if (ifPend && starve == STARVE_MAX) eI = 1'b1;
      else if (dPend) eD = 1'b1;
      else if (ifPend) eI = 1'b1;
    end
    eWrite = eD && iDWrite;
    eRead  = eI || (eD && !iDWrite);
    if (eI) eGrant = 2'b01;
    else if (eD) eGrant = 2'b10;
    else if (!iRST && busyLeft > 0) eGrant = waitOwner;
    else eGrant = 2'b00;

    check("m_read", oMRead, eRead);
    check("m_write", oMWrite, eWrite);
    check("grant", oGrant, eGrant);
    check("i_stall", oIStall, ifPend);
    check("d_stall", oDStall, dPend);
    check("i_valid", oIValid, mIValid);
    check("d_valid", oDValid, mDValid);
    check("i_rdata", oIRdata, mIRdata);
    check("d_rdata", oDRdata, mDRdata);
    if (eRead || eWrite) check("m_addr", oMAddr, eI ? iIAddr : iDAddr);
    if (eRead) check("m_be_rd", oMBE, 32'h0);
    if (eWrite) begin
      check("m_be_wr", oMBE, iDBE);
      check("m_wdata", oMWdata, iDWdata);
    end

    nI = 1'b0;
    nD = 1'b0;
    if (iRST) begin
      busyLeft   = 0;
      pendActive = 1'b0;
      starve     = 0;
      mIRdata    = '0;
      mDRdata    = '0;
    end else begin
      if (eI || !iIReq) starve = 0;
      else if (eD && starve < STARVE_MAX) starve++;
      if (eWrite) begin
        refMem[iDAddr] = merge(ref_read(iDAddr), iDWdata, iDBE);
        nD = 1'b1;
      end
      if (eRead) begin
        pendActive = 1'b1;
        pendDue    = cyc + MEM_LAT;
        pendIsI    = eI;
        pendData   = ref_read(eI ? iIAddr : iDAddr);
        busyLeft   = MEM_LAT - 1;
        waitOwner  = eI ? 2'b01 : 2'b10;
      end else if (busyLeft > 0) begin
        busyLeft--;
      end
      if (pendActive && pendDue == cyc + 1) begin
        pendActive = 1'b0;
        if (pendIsI) begin
          nI = 1'b1;
          mIRdata = pendData;
        end else begin
          nD = 1'b1;
          mDRdata = pendData;
        end
      end
    end
    mIValid = nI;
    mDValid = nD;
    cyc++;
  end

  // ---------------- driver tasks ----------------
  task automatic next_cycle();
    @(posedge iCLK);
    #1;
  endtask

  task automatic mid();
    @(negedge iCLK);
    #1;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) next_cycle();
  endtask

  // ---------------- stimulus ----------------
  logic       served;
  logic       dDone;
  int         nd;
  int         ni;
  logic [1:0] issues [2];
  logic       ifBusy;
  logic       dBusy;

  initial begin
    iRST = 1'b1; iIReq = 1'b0; iIAddr = '0;
    iDRead = 1'b0; iDWrite = 1'b0; iDAddr = '0; iDWdata = '0; iDBE = '0;
    preload(32'h0040_0000, 32'h2408_000A);
    preload(32'h1001_0000, 32'h8C09_0004);
    preload(32'h1001_0008, 32'h1122_3344);
    repeat (3) @(posedge iCLK);
    #1 iRST = 1'b0;

    // reset state
    mid();
    check("rst_ivalid", oIValid, 0);
    check("rst_dvalid", oDValid, 0);
    check("rst_grant", oGrant, 0);
    check("rst_irdata", oIRdata, 0);
    check("rst_mread", oMRead, 0);

    // IF-only read
    next_cycle(); iIReq = 1'b1; iIAddr = 32'h0040_0000;
    mid(); check("t1_mread", oMRead, 1); check("t1_stall_t", oIStall, 1);
    next_cycle(); mid(); check("t1_stall_t1", oIStall, 1); check("t1_early", oIValid, 0);
    next_cycle(); mid(); check("t1_ivalid", oIValid, 1); check("t1_irdata", oIRdata, 32'h2408_000A);
    check("t1_stall_end", oIStall, 0);
    next_cycle(); iIReq = 1'b0;
    idle(2);

    // IF and data read together: data first, then IF
    iIReq = 1'b1; iIAddr = 32'h0040_0000; iDRead = 1'b1; iDAddr = 32'h1001_0000;
    mid(); check("t2_grant_d", oGrant, 2'b10); check("t2_maddr_d", oMAddr, 32'h1001_0000);
    next_cycle(); iDAddr = 32'h1001_0FF0;
    next_cycle(); mid(); check("t2_dvalid", oDValid, 1); check("t2_drdata", oDRdata, 32'h8C09_0004);
    check("t2_grant_i", oGrant, 2'b01); check("t2_maddr_i", oMAddr, 32'h0040_0000);
    next_cycle(); iDRead = 1'b0;
    next_cycle(); mid(); check("t2_ivalid", oIValid, 1); check("t2_irdata", oIRdata, 32'h2408_000A);
    next_cycle(); iIReq = 1'b0;
    idle(2);

    // data write with partial byte enables, then read it back
    iDWrite = 1'b1; iDAddr = 32'h1001_0008; iDWdata = 32'hDEAD_BEEF; iDBE = 4'b0011;
    mid(); check("t3_mwrite", oMWrite, 1); check("t3_mbe", oMBE, 4'b0011);
    check("t3_mwdata", oMWdata, 32'hDEAD_BEEF); check("t3_mread", oMRead, 0);
    next_cycle(); iDWdata = 32'h0; iDBE = 4'b1111;
    mid(); check("t3_dvalid", oDValid, 1); check("t3_dstall", oDStall, 0);
    next_cycle(); iDWrite = 1'b0; iDRead = 1'b1;
    next_cycle(); next_cycle();
    mid(); check("t3_readback", oDRdata, 32'h1122_BEEF);
    next_cycle(); iDRead = 1'b0;
    idle(2);

    // read and write together is a single write
    iDRead = 1'b1; iDWrite = 1'b1; iDAddr = 32'h1001_000C; iDWdata = 32'hCAFE_F00D; iDBE = 4'b1111;
    mid(); check("t6_mwrite", oMWrite, 1); check("t6_mread", oMRead, 0);
    next_cycle(); mid(); check("t6_dvalid", oDValid, 1); check("t6_mwrite_t1", oMWrite, 0);
    next_cycle(); iDRead = 1'b0; iDWrite = 1'b0;
    idle(2);

    // continuous data reads with IF pending: IF must still be served
    iIReq = 1'b1; iIAddr = 32'h0040_0000; iDRead = 1'b1; iDAddr = 32'h1001_0000;
    served = 1'b0; nd = 0; ni = 0; issues[0] = 2'b00; issues[1] = 2'b00;
    for (int k = 0; k < 20 && !served; k++) begin
      mid();
      if (oMRead && ni < 2) begin
        issues[ni] = oGrant;
        ni++;
      end
      if (oDValid) nd++;
      if (oIValid) served = 1'b1;
      else begin
        next_cycle();
        if (oDValid) iDAddr = rand_addr();
      end
    end
    check("t4_if_served", served, 1);
    check("t4_d_before_i", nd <= STARVE_MAX, 1);
    check("t4_first_d", issues[0], 2'b10);
    check("t4_then_i", issues[1], 2'b01);
    next_cycle(); iIReq = 1'b0;
    dDone = 1'b0;
    for (int k = 0; k < 10 && !dDone; k++) begin
      mid();
      if (oDValid) dDone = 1'b1;
      else next_cycle();
    end
    check("t4_d_drain", dDone, 1);
    next_cycle(); iDRead = 1'b0;
    idle(2);

    // reset during a read: no completion, then a fresh read works
    iDRead = 1'b1; iDAddr = 32'h1001_0000;
    mid(); check("t5_mread", oMRead, 1);
    next_cycle(); iRST = 1'b1; iDRead = 1'b0;
    mid(); check("t5_rst_mread", oMRead, 0); check("t5_rst_grant", oGrant, 0);
    next_cycle(); iRST = 1'b0;
    mid(); check("t5_no_dvalid", oDValid, 0); check("t5_mwrite", oMWrite, 0);
    next_cycle(); mid(); check("t5_no_dvalid2", oDValid, 0);
    next_cycle(); iDRead = 1'b1; iDAddr = 32'h1001_0000;
    mid(); check("t5_fresh_mread", oMRead, 1);
    next_cycle(); next_cycle();
    mid(); check("t5_fresh_dvalid", oDValid, 1); check("t5_fresh_drdata", oDRdata, 32'h8C09_0004);
    next_cycle(); iDRead = 1'b0;
    idle(2);

    // randomized traffic on both ports
    ifBusy = 1'b0;
    dBusy  = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      next_cycle();
      iRST = ($urandom_range(0, 199) == 0);
      if (ifBusy && oIValid) begin
        ifBusy = 1'b0;
        if ($urandom_range(0, 1) == 0) iIReq = 1'b0;
      end else if (!ifBusy) begin
        if ($urandom_range(0, 2) == 0) begin
          ifBusy = 1'b1; iIReq = 1'b1; iIAddr = rand_addr();
        end else begin
          iIReq = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        iIAddr = rand_addr();
      end
      if (dBusy && oDValid) begin
        dBusy = 1'b0;
        if ($urandom_range(0, 1) == 0) begin
          iDRead = 1'b0; iDWrite = 1'b0;
        end
      end else if (!dBusy) begin
        if ($urandom_range(0, 1) == 0) begin
          dBusy = 1'b1;
          case ($urandom_range(0, 3))
            0, 1:    begin iDRead = 1'b1; iDWrite = 1'b0; end
            2:       begin iDRead = 1'b0; iDWrite = 1'b1; end
            default: begin iDRead = 1'b1; iDWrite = 1'b1; end
          endcase
          iDAddr = rand_addr(); iDWdata = $urandom(); iDBE = 4'($urandom_range(0, 15));
        end else begin
          iDRead = 1'b0; iDWrite = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        iDAddr = rand_addr(); iDWdata = $urandom(); iDBE = 4'($urandom_range(0, 15));
      end
    end
    next_cycle();
    iRST = 1'b0; iIReq = 1'b0; iDRead = 1'b0; iDWrite = 1'b0;
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
